// File: rtl/seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_unit
// Brief    : Multi-cycle shift-add multiplier for the MULT/MULTU function
//            codes. One multiplier bit per cycle, signed and unsigned modes,
//            start/busy/done handshake, 2*WIDTH-bit product held on dataOut.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_unit #(
  parameter int         WIDTH    = 32,
  parameter logic [5:0] MULTU_OP = 6'b011001,
  parameter logic [5:0] MULT_OP  = 6'b011000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [5:0]           Signal,
  input  logic [WIDTH-1:0]     dataA,
  input  logic [WIDTH-1:0]     dataB,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   dataOut
);

  // Step counter only needs to reach WIDTH-1.
  localparam int                   c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0]   c_ONE   = c_CNT_W'(1);
  localparam logic [WIDTH-1:0]     c_ZERO_W  = '0;
  localparam logic [2*WIDTH-1:0]   c_ZERO_2W = '0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [2*WIDTH-1:0]   r_mcand;     // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]     r_mplier;    // multiplier magnitude, shifted right each step
  logic [2*WIDTH-1:0]   r_acc;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_neg;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_dataout;

  logic                 w_is_mult;
  logic                 w_is_multu;
  logic                 w_accept;
  logic                 w_step;
  logic                 w_final;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_neg;
  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_acc_next;
  logic [2*WIDTH-1:0]   w_result;

  // Next-state and step control: accept only a valid opcode in IDLE, run WIDTH steps.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_step       = 1'b0;
    w_final      = 1'b0;
    w_is_mult    = (Signal == MULT_OP);
    w_is_multu   = (Signal == MULTU_OP);
    case (r_state)
      S_IDLE: begin
        if (start && (w_is_mult || w_is_multu)) begin
          w_accept     = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_count == c_LAST) begin
          w_final      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand magnitudes, sign of result, and the per-step accumulate/final negate.
  // The magnitude of the most negative value wraps to itself, which read as
  // unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
  always_comb begin
    w_a_mag    = dataA;
    w_b_mag    = dataB;
    w_neg      = 1'b0;
    if (w_is_mult) begin
      if (dataA[WIDTH-1]) w_a_mag = c_ZERO_W - dataA;
      if (dataB[WIDTH-1]) w_b_mag = c_ZERO_W - dataB;
      w_neg = dataA[WIDTH-1] ^ dataB[WIDTH-1];
    end
    w_addend   = r_mplier[0] ? r_mcand : c_ZERO_2W;
    w_acc_next = r_acc + w_addend;
    w_result   = r_neg ? (c_ZERO_2W - w_acc_next) : w_acc_next;
  end

  // State register; reset returns to IDLE from anywhere, aborting a running op.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_neg     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dataout <= '0;
    end else begin
      r_done <= w_final;
      if (w_accept) begin
        r_mcand  <= {c_ZERO_W, w_a_mag};
        r_mplier <= w_b_mag;
        r_acc    <= '0;
        r_count  <= '0;
        r_neg    <= w_neg;
        r_busy   <= 1'b1;
      end else if (w_step) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + c_ONE;
        if (w_final) begin
          r_busy    <= 1'b0;
          r_dataout <= w_result;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign dataOut = r_dataout;

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_unit
// Brief    : Directed self-checking bench for seq_mult_unit (WIDTH=32 and 8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_unit;

  localparam logic [5:0] c_MULTU = 6'b011001;
  localparam logic [5:0] c_MULT  = 6'b011000;
  localparam logic [5:0] c_BAD   = 6'b100000;

  logic        clk;
  logic        reset;

  logic        start32;
  logic [5:0]  sig32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] out32;

  logic        start8;
  logic [5:0]  sig8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] out8;

  int checks   = 0;
  int failures = 0;

  seq_mult_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start32), .Signal(sig32),
    .dataA(a32), .dataB(b32), .busy(busy32), .done(done32), .dataOut(out32)
  );

  seq_mult_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .Signal(sig8),
    .dataA(a8), .dataB(b8), .busy(busy8), .done(done8), .dataOut(out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // done must never coincide with busy
  always @(negedge clk) begin
    if (done32) check("done32_not_busy", 64'(busy32), 64'd0);
    if (done8)  check("done8_not_busy",  64'(busy8),  64'd0);
  end

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue32(input logic [5:0] s, input logic [31:0] a, input logic [31:0] b);
    start32 = 1'b1; sig32 = s; a32 = a; b32 = b;
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic issue8(input logic [5:0] s, input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1; sig8 = s; a8 = a; b8 = b;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // Counts cycles from the negedge after accept until done is seen.
  task automatic wait_done32(output int n);
    n = 0;
    while (!done32 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done32) check("timeout32", 64'd0, 64'd1);
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    while (!done8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done8) check("timeout8", 64'd0, 64'd1);
  endtask

  int  n;
  bit  saw_done;

  initial begin
    reset = 1'b0;
    start32 = 1'b0; sig32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; sig8  = '0; a8  = '0; b8  = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: mid-idle reset, then an invalid opcode
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy",    64'(busy32), 64'd0);
    check("rst_done",    64'(done32), 64'd0);
    check("rst_dataout", out32,       64'd0);
    reset = 1'b1;
    @(negedge clk);
    issue32(c_BAD, 32'd3, 32'd4);
    check("bad_op_busy", 64'(busy32), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done32) saw_done = 1'b1;
    end
    check("bad_op_done", 64'(saw_done), 64'd0);

    // 2: unsigned full-scale with latency
    issue32(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_busy", 64'(busy32), 64'd1);
    wait_done32(n);
    check("multu_latency", 64'(n), 64'd32);
    check("multu_max", out32, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);
    check("done_one_cycle", 64'(done32), 64'd0);

    // 3: signed
    issue32(c_MULT, 32'hFFFF_FFFD, 32'h0000_0005);
    wait_done32(n);
    check("mult_neg3x5", out32, 64'hFFFF_FFFF_FFFF_FFF1);
    issue32(c_MULT, 32'h8000_0000, 32'h8000_0000);
    wait_done32(n);
    check("mult_minxmin", out32, 64'h4000_0000_0000_0000);

    // 4: start ignored while busy, operands changed mid-op; back-to-back in done cycle
    issue32(c_MULTU, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    start32 = 1'b1; a32 = 32'd100; b32 = 32'd200;
    @(negedge clk);
    start32 = 1'b0; a32 = 32'h1234_5678;
    wait_done32(n);
    check("ignore_busy_result", out32, 64'd12);
    issue32(c_MULT, 32'hFFFF_FFFE, 32'd7);
    check("b2b_busy", 64'(busy32), 64'd1);
    wait_done32(n);
    check("b2b_latency", 64'(n), 64'd32);
    check("b2b_result", out32, 64'hFFFF_FFFF_FFFF_FFF2);

    // 5: reset after 10 steps aborts the op
    issue32(c_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy",    64'(busy32), 64'd0);
    check("abort_dataout", out32,       64'd0);
    check("abort_done",    64'(done32), 64'd0);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done32) saw_done = 1'b1;
    end
    check("abort_no_done", 64'(saw_done), 64'd0);
    issue32(c_MULTU, 32'd7, 32'd6);
    wait_done32(n);
    check("after_abort", out32, 64'h2A);

    // 6: 8-bit instance
    issue8(c_MULT, 8'h80, 8'h7F);
    wait_done8(n);
    check("w8_latency", 64'(n), 64'd8);
    check("w8_mult", 64'(out8), 64'hC080);
    issue8(c_MULTU, 8'h80, 8'h7F);
    wait_done8(n);
    check("w8_multu", 64'(out8), 64'h3F80);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
